datapath_scheduler: RTL and testbench

Round-robin scheduler that shares one 8-bit adder/combinational/mux datapath among three requesters. It grants one operand triple at a time and drives it into the datapath input registers with a load strobe. After a fixed pipeline latency it captures the two datapath results and returns them to the winner, tagged with the requester ID, on a valid/ready response channel. It sits between the requesting units and the datapath top, and is the only source of datapath operands.

---
 rtl/datapath_scheduler.sv | 112 +++++++++++
 tb/tb_datapath_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_scheduler.sv
// Round-robin scheduler sharing one datapath among three requesters: grants one
// operand triple, strobes it into the datapath, captures results after LATENCY cycles.
module datapath_scheduler #(
   parameter int W       = 8,
   parameter int LATENCY = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [2:0]     req,
   input  logic [3*W-1:0] op1,
   input  logic [3*W-1:0] op2,
   input  logic [3*W-1:0] op3,
   output logic [2:0]     grant,
   output logic [W-1:0]   dp_in1,
   output logic [W-1:0]   dp_in2,
   output logic [W-1:0]   dp_in3,
   output logic           dp_load,
   input  logic [W-1:0]   dp_out1,
   input  logic [W-1:0]   dp_out2,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [1:0]     resp_id,
   output logic [W-1:0]   resp_out1,
   output logic [W-1:0]   resp_out2,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t     state;
   logic [1:0] ptr;
   logic [3:0] cnt;
   logic [1:0] win;
   logic       win_vld;

   function automatic logic [1:0] rr_idx(input logic [1:0] base, input int unsigned off);
      int unsigned s;
      s = int'(base) + off;
      if (s >= 3) s = s - 3;
      return s[1:0];
   endfunction

   function automatic logic [1:0] next_ptr(input logic [1:0] k);
      return (k == 2'd2) ? 2'd0 : k + 2'd1;
   endfunction

   // First requester found scanning from ptr upward (mod 3) wins.
   always_comb begin
      win     = 2'd0;
      win_vld = 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (!win_vld && req[rr_idx(ptr, j)]) begin
            win     = rr_idx(ptr, j);
            win_vld = 1'b1;
         end
      end
   end

   assign grant = (reset_n && state == IDLE && win_vld) ? (3'b001 << win) : 3'b000;
   assign busy  = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ptr        <= 2'd0;
         cnt        <= 4'd0;
         dp_in1     <= '0;
         dp_in2     <= '0;
         dp_in3     <= '0;
         dp_load    <= 1'b0;
         resp_valid <= 1'b0;
         resp_id    <= 2'd0;
         resp_out1  <= '0;
         resp_out2  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  dp_in1  <= op1[int'(win)*W +: W];
                  dp_in2  <= op2[int'(win)*W +: W];
                  dp_in3  <= op3[int'(win)*W +: W];
                  dp_load <= 1'b1;
                  resp_id <= win;
                  ptr     <= next_ptr(win);
                  cnt     <= 4'(LATENCY);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               dp_load <= 1'b0;
               // cnt reaches zero exactly when the datapath presents this load's results.
               if (cnt == 4'd0) begin
                  resp_out1  <= dp_out1;
                  resp_out2  <= dp_out2;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_datapath_scheduler.sv
// Randomized scoreboard bench for datapath_scheduler: a cycle-level reference model
// predicts grants, loads and responses; a monitor checks every presented response.
module tb_datapath_scheduler;
   localparam int W   = 8;
   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset_n;
   logic [2:0]     req;
   logic [3*W-1:0] op1, op2, op3;
   logic [2:0]     grant;
   logic [W-1:0]   dp_in1, dp_in2, dp_in3;
   logic           dp_load;
   logic [W-1:0]   dp_out1, dp_out2;
   logic           resp_valid, resp_ready;
   logic [1:0]     resp_id;
   logic [W-1:0]   resp_out1, resp_out2;
   logic           busy;

   logic [2:0]     req_b;
   logic [3*W-1:0] op1_b, op2_b, op3_b;
   logic [2:0]     grant_b;
   logic [W-1:0]   dp_in1_b, dp_in2_b, dp_in3_b;
   logic           dp_load_b;
   logic [W-1:0]   dp_out1_b, dp_out2_b;
   logic           resp_valid_b, resp_ready_b;
   logic [1:0]     resp_id_b;
   logic [W-1:0]   resp_out1_b, resp_out2_b;
   logic           busy_b;

   datapath_scheduler #(.W(W), .LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .op1(op1), .op2(op2), .op3(op3),
      .grant(grant), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_in3(dp_in3), .dp_load(dp_load),
      .dp_out1(dp_out1), .dp_out2(dp_out2), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_out1(resp_out1), .resp_out2(resp_out2), .busy(busy));

   datapath_scheduler #(.W(W), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset_n(reset_n), .req(req_b), .op1(op1_b), .op2(op2_b), .op3(op3_b),
      .grant(grant_b), .dp_in1(dp_in1_b), .dp_in2(dp_in2_b), .dp_in3(dp_in3_b),
      .dp_load(dp_load_b), .dp_out1(dp_out1_b), .dp_out2(dp_out2_b),
      .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_id(resp_id_b),
      .resp_out1(resp_out1_b), .resp_out2(resp_out2_b), .busy(busy_b));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Datapath stand-in: results of a load appear LAT cycles after the load cycle,
   // random junk otherwise, so a mistimed capture is visible.
   function automatic logic [15:0] dp_f(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      return {a + b, c[0] ? a : (b ^ c)};
   endfunction

   logic [15:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= dp_load ? dp_f(dp_in1, dp_in2, dp_in3) : 16'($urandom);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign dp_out1 = pipe[LAT-1][15:8];
   assign dp_out2 = pipe[LAT-1][7:0];

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] o1;
      logic [7:0] o2;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   logic [2:0] pend;
   logic [7:0] ro1 [3];
   logic [7:0] ro2 [3];
   logic [7:0] ro3 [3];
   logic [2:0] last_grant;

   int         cyc;
   int         m_ptr, m_free, m_rv_start, m_load_cyc, m_grant_cyc;
   bit         m_pend;
   logic [7:0] m_d1, m_d2, m_d3, m_l1, m_l2, m_l3;

   task automatic model_reset();
      m_ptr = 0; m_pend = 0; m_free = 0; m_rv_start = 0;
      m_load_cyc = -10; m_grant_cyc = -10;
      m_d1 = 0; m_d2 = 0; m_d3 = 0;
      sbq.delete();
      last_grant = 3'b000;
      pend = 3'b000;
   endtask

   task automatic drive_ops();
      req = pend;
      op1 = {ro1[2], ro1[1], ro1[0]};
      op2 = {ro2[2], ro2[1], ro2[0]};
      op3 = {ro3[2], ro3[1], ro3[0]};
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      pend[i] = 1'b1; ro1[i] = a; ro2[i] = b; ro3[i] = c;
   endtask

   // Scheduler as seen from outside: one transaction at a time, response from
   // grant+2+LAT until accepted, next grant no earlier than the cycle after acceptance.
   task automatic model_check();
      logic       exp_valid, exp_busy, exp_load;
      logic [2:0] exp_grant;
      int         k;
      exp_valid = m_pend && (cyc >= m_rv_start);
      exp_busy  = m_pend && (cyc > m_grant_cyc);
      exp_load  = (cyc == m_load_cyc);
      if (exp_load) begin m_d1 = m_l1; m_d2 = m_l2; m_d3 = m_l3; end
      exp_grant = 3'b000;
      if (exp_valid && resp_ready) begin m_pend = 0; m_free = cyc + 1; end
      if (!m_pend && cyc >= m_free && req != 3'b000) begin
         k = -1;
         for (int j = 0; j < 3; j++)
            if (k < 0 && req[(m_ptr + j) % 3]) k = (m_ptr + j) % 3;
         exp_grant   = 3'(1 << k);
         m_pend      = 1;
         m_grant_cyc = cyc;
         m_load_cyc  = cyc + 1;
         m_rv_start  = cyc + 2 + LAT;
         m_l1 = ro1[k]; m_l2 = ro2[k]; m_l3 = ro3[k];
         sbq.push_back({2'(k), dp_f(ro1[k], ro2[k], ro3[k])});
         m_ptr = (k + 1) % 3;
      end
      chk("grant", grant, exp_grant);
      chk("dp_load", dp_load, exp_load);
      chk("dp_in", {dp_in1, dp_in2, dp_in3}, {m_d1, m_d2, m_d3});
      chk("resp_valid", resp_valid, exp_valid);
      chk("busy", busy, exp_busy);
      last_grant = grant;
   endtask

   task automatic step(input int p_req, input int p_rdy);
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < 3; i++) if (pend[i] && last_grant[i]) pend[i] = 1'b0;
      for (int i = 0; i < 3; i++)
         if (!pend[i] && $urandom_range(99) < p_req)
            set_req(i, 8'($urandom), 8'($urandom), 8'($urandom));
      drive_ops();
      resp_ready = ($urandom_range(99) < p_rdy);
      @(negedge clk);
      model_check();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_grant"}, grant, 3'b000);
      chk({tag, "_dp"}, {dp_load, dp_in1, dp_in2, dp_in3}, 0);
      chk({tag, "_resp"}, {resp_valid, resp_id, resp_out1, resp_out2}, 0);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   always @(negedge clk) begin
      if (reset_n && resp_valid) begin
         if (sbq.size() == 0) begin
            chk("resp_unexpected", 1, 0);
         end else begin
            mon_e = sbq[0];
            chk("resp_id", resp_id, mon_e.id);
            chk("resp_out", {resp_out1, resp_out2}, {mon_e.o1, mon_e.o2});
            if (resp_ready) void'(sbq.pop_front());
         end
      end
   end

   logic [2:0] gorder[$];
   bit         found;

   initial begin
      reset_n = 1'b0; resp_ready = 1'b0; cyc = 0;
      for (int i = 0; i < 3; i++) begin ro1[i] = 0; ro2[i] = 0; ro3[i] = 0; end
      model_reset();
      drive_ops();
      req = 3'b111;
      req_b = 3'b000; op1_b = '0; op2_b = '0; op3_b = '0;
      dp_out1_b = 8'h11; dp_out2_b = 8'h22; resp_ready_b = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      req = 3'b000;
      #2 reset_n = 1'b1;

      // All three requesting continuously from reset.
      for (int c = 0; c < 30; c++) begin
         step(100, 100);
         if (grant != 3'b000) gorder.push_back(grant);
      end
      if (gorder.size() >= 4) begin
         chk("rr_order0", gorder[0], 3'b001);
         chk("rr_order1", gorder[1], 3'b010);
         chk("rr_order2", gorder[2], 3'b100);
         chk("rr_order3", gorder[3], 3'b001);
      end else chk("rr_order_count", gorder.size(), 4);
      repeat (20) step(0, 100);

      // Single request and its exact timing.
      set_req(0, 8'h10, 8'h20, 8'h30);
      step(0, 100);
      chk("single_grant", grant, 3'b001);
      step(0, 100);
      chk("single_load", {dp_load, dp_in1, dp_in2, dp_in3}, {1'b1, 8'h10, 8'h20, 8'h30});
      step(0, 100);
      step(0, 100);
      step(0, 100);
      chk("single_resp", {resp_valid, resp_id, resp_out1, resp_out2},
          {1'b1, 2'd0, dp_f(8'h10, 8'h20, 8'h30)});
      step(0, 100);

      // ptr now 1: requester 2 must win over 0.
      set_req(0, 8'h01, 8'h02, 8'h03);
      set_req(2, 8'h07, 8'h08, 8'h09);
      step(0, 100);
      chk("rr_skip", grant, 3'b100);
      repeat (15) step(0, 100);

      // Backpressure: ready low through a long RESP with a competing request.
      set_req(1, 8'hC3, 8'h3C, 8'h5A);
      step(0, 0);
      set_req(2, 8'h44, 8'h55, 8'h66);
      repeat (15) step(0, 0);
      chk("bp_holding", {resp_valid, resp_id}, {1'b1, 2'd1});
      repeat (20) step(0, 100);

      // Randomized traffic with varying load and backpressure.
      for (int blk = 0; blk < 8; blk++) begin
         int pr, py;
         pr = int'($urandom_range(90, 20));
         py = int'($urandom_range(100, 30));
         repeat (50) step(pr, py);
      end
      repeat (25) step(0, 100);
      chk("sb_empty", sbq.size(), 0);

      // Reset in the second WAIT cycle.
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         step(100, 100);
         if (m_pend && cyc == m_grant_cyc + 2) found = 1;
      end
      chk("reach_wait2", found, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_vals("midreset");
      model_reset();
      drive_ops();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (20) step(0, 100);

      // LATENCY=1 instance timing.
      @(posedge clk); #1;
      req_b = 3'b001; op1_b = {16'h0, 8'h10}; op2_b = {16'h0, 8'h20}; op3_b = {16'h0, 8'h30};
      @(negedge clk);
      chk("l1_grant", grant_b, 3'b001);
      @(posedge clk); #1 req_b = 3'b000;
      @(negedge clk);
      chk("l1_load", {dp_load_b, dp_in1_b, dp_in2_b, dp_in3_b}, {1'b1, 8'h10, 8'h20, 8'h30});
      @(posedge clk); #1 dp_out1_b = 8'hAA; dp_out2_b = 8'h55;
      @(negedge clk);
      chk("l1_wait", {resp_valid_b, dp_load_b, busy_b}, 3'b001);
      @(posedge clk); #1 dp_out1_b = 8'h11; dp_out2_b = 8'h22;
      @(negedge clk);
      chk("l1_resp", {resp_valid_b, resp_id_b, resp_out1_b, resp_out2_b}, {1'b1, 2'd0, 8'hAA, 8'h55});
      @(posedge clk);
      @(negedge clk);
      chk("l1_idle", {resp_valid_b, busy_b}, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
